// File: rtl/ether_width_packer.sv
// ether_width_packer: packs a stream of IN_W-bit words into OUT_W-bit words, MSB-first.
// Valid/ready on both sides, zero-padded flush on endRun, FlushDone pulse and a
// per-run count of consumed output words.
module ether_width_packer #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16,
    parameter int CNT_W = 24
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [IN_W-1:0]  DataIn,
    input  logic             StrobeIn,
    output logic             ReadyIn,
    input  logic             endRun,
    output logic [OUT_W-1:0] DataOut,
    output logic             StrobeOut,
    input  logic             ReadyOut,
    output logic             FlushDone,
    output logic [CNT_W-1:0] WordCount
);

    // Accumulator holds at most OUT_W-1 residual bits plus one accepted word.
    localparam int ACC_W  = IN_W + OUT_W - 1;
    localparam int FILL_W = $clog2(ACC_W + 1);

    localparam logic [FILL_W-1:0] OUT_FILL = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] IN_FILL  = FILL_W'(IN_W);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state_q,  state_d;
    logic [FILL_W-1:0] fill_q,   fill_d;
    logic [ACC_W-1:0]  acc_q,    acc_d;
    logic [OUT_W-1:0]  data_q,   data_d;
    logic              strobe_q, strobe_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    logic              accept;
    logic              out_free;
    logic              consume;
    logic              emit_full;
    logic              emit_pad;
    logic [ACC_W-1:0]  in_aligned;
    logic [ACC_W-1:0]  acc_base;
    logic [FILL_W-1:0] fill_base;

    assign ReadyIn   = (state_q == ST_RUN) && (fill_q < OUT_FILL);
    assign accept    = StrobeIn && ReadyIn;
    assign out_free  = !strobe_q || ReadyOut;
    assign consume   = strobe_q && ReadyOut;

    // Emission decisions look at the fill level before this cycle's accept.
    assign emit_full = out_free && (fill_q >= OUT_FILL);
    assign emit_pad  = out_free && (state_q == ST_FLUSH) &&
                       (fill_q != '0) && (fill_q < OUT_FILL);

    // Incoming word placed at the top of the accumulator before shifting into position.
    assign in_aligned = ACC_W'(DataIn) << (ACC_W - IN_W);

    assign DataOut   = data_q;
    assign StrobeOut = strobe_q;
    assign FlushDone = (state_q == ST_DONE);
    assign WordCount = count_q;

    // Accumulator: remove the emitted word first, then append the accepted word below the residue.
    always_comb begin
        acc_base  = acc_q;
        fill_base = fill_q;
        if (emit_full) begin
            acc_base  = acc_q << OUT_W;
            fill_base = fill_q - OUT_FILL;
        end else if (emit_pad) begin
            // Bits below the valid region are always zero, so the top slice is already padded.
            acc_base  = '0;
            fill_base = '0;
        end
        acc_d  = acc_base;
        fill_d = fill_base;
        if (accept) begin
            acc_d  = acc_base | (in_aligned >> fill_base);
            fill_d = fill_base + IN_FILL;
        end
    end

    // Output register: load on emit, drop strobe when free and nothing to load, else hold.
    always_comb begin
        data_d   = data_q;
        strobe_d = strobe_q;
        if (emit_full || emit_pad) begin
            data_d   = acc_q[ACC_W-1 -: OUT_W];
            strobe_d = 1'b1;
        end else if (out_free) begin
            strobe_d = 1'b0;
        end
    end

    // Run / flush / done sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (endRun) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if ((fill_q == '0) && !strobe_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Consumed-word counter, cleared as the flush completes.
    always_comb begin
        if (state_q == ST_DONE) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(consume);
        end
    end

    // State registers with synchronous reset discarding any held bits.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_RUN;
            fill_q   <= '0;
            acc_q    <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            acc_q    <= acc_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            count_q  <= count_d;
        end
    end

endmodule
